store_merge_rmw: RTL and testbench

- Parametrised successor to the combinational store-size merge in the multicycle datapath.
- Performs full-word stores directly.
- Performs byte and halfword stores as a sequenced read-modify-write: fetch the aligned memory word, insert the store data into the byte lanes selected by the address, write the merged word back.
- Sits between the control unit / B register and the data memory port; the control unit holds in a wait state until done or err.

---
 rtl/store_merge_rmw_pkg.sv | 29 ++
 rtl/store_merge_rmw_lane_merge.sv | 39 +++
 rtl/store_merge_rmw.sv | 165 ++++++++++++++++
 tb/tb_store_merge_rmw.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_merge_rmw_pkg.sv
// Shared definitions for the store-merge read-modify-write unit.
// Holds store-size encodings, FSM state codes and a width helper.
// Imported by the top level and the lane merge sub-module.
package store_merge_rmw_pkg;

  // Store size encodings carried on req_size.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  // FSM state codes.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/store_merge_rmw_lane_merge.sv
// Byte-lane merge: inserts store data into the lanes selected by size/offset.
// Latency: purely combinational.
// Backpressure: none; caller decides when the result is captured.
module store_merge_rmw_lane_merge
  import store_merge_rmw_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic [OFF_W-1:0]  off_i,
  output logic [DATA_W-1:0] merged_o
);

  localparam int NBYTES = DATA_W / 8;

  logic [OFF_W:0] off_hi;

  assign off_hi = {1'b0, off_i} + 1'b1;

  // Start from the memory word and overwrite only the lanes the store covers;
  // the halfword's low byte lands in lane off (little-endian).
  always_comb begin
    merged_o = rdata_i;
    if (size_i == SZ_WORD) begin
      merged_o = data_i;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if ((size_i == SZ_BYTE || size_i == SZ_HALF) && off_i == OFF_W'(i))
          merged_o[i*8 +: 8] = data_i[7:0];
        if (size_i == SZ_HALF && off_hi == (OFF_W+1)'(i))
          merged_o[i*8 +: 8] = data_i[15:8];
      end
    end
  end

endmodule

// File: rtl/store_merge_rmw.sv
// Store unit: full-word stores written directly, sub-word stores via read-modify-write.
// Latency: word store done at T+1, sub-word done at T+2+MEM_LAT, reject err at T+1.
// Backpressure: req_ready only in IDLE; one request in flight, no queue.
module store_merge_rmw
  import store_merge_rmw_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int OFF_W  = clog2(NBYTES);
  localparam int CNT_W  = clog2(MEM_LAT) + 1;

  logic [2:0]        state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [OFF_W-1:0]  req_off;
  logic              req_legal;
  logic [DATA_W-1:0] merged;

  assign req_off = req_addr[OFF_W-1:0];

  // Alignment rules: word needs off 0, halfword an even off, byte anything.
  always_comb begin
    req_legal = 1'b0;
    case (req_size)
      SZ_WORD: req_legal = (req_off == '0);
      SZ_HALF: req_legal = ~req_off[0];
      SZ_BYTE: req_legal = 1'b1;
      default: req_legal = 1'b0;
    endcase
  end

  // Merge against the live read data; captured only on the last WAIT cycle.
  store_merge_rmw_lane_merge #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_lane_merge (
    .rdata_i  (mem_rdata),
    .data_i   (data_q),
    .size_i   (size_q),
    .off_i    (off_q),
    .merged_o (merged)
  );

  // Next-state and registered-output decode; strobes default low each cycle.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    off_d       = off_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_rd_d    = 1'b0;
    mem_wr_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          size_d = req_size;
          off_d  = req_off;
          data_d = req_data;
          if (!req_legal) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            mem_addr_d = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            if (req_size == SZ_WORD) begin
              state_d     = ST_WRITE;
              mem_wr_d    = 1'b1;
              done_d      = 1'b1;
              mem_wdata_d = req_data;
            end else begin
              state_d  = ST_READ;
              mem_rd_d = 1'b1;
            end
          end
        end
      end
      ST_READ: begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(MEM_LAT - 1);
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ST_WRITE;
          mem_wr_d    = 1'b1;
          done_d      = 1'b1;
          mem_wdata_d = merged;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any operation and drops strobes at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      size_q      <= SZ_WORD;
      off_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      off_q       <= off_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_rd    = mem_rd_q;
  assign mem_wr    = mem_wr_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_merge_rmw.sv
// Scoreboard bench for store_merge_rmw with a latency-accurate memory model.
// Stimulus pushes expected responses; a monitor pops and compares on each strobe.
// Also exercises the lane merge standalone at 64-bit width.
module tb_store_merge_rmw;
  import store_merge_rmw_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int LAT = 3;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [DW-1:0] mem_rdata;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic          done;
  logic          err;

  logic [63:0] lm_rdata, lm_data, lm_out;
  logic [1:0]  lm_size;
  logic [2:0]  lm_off;

  typedef struct {
    bit          is_err;
    bit          sub;
    bit          rd_seen;
    int          t_acc;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [logic [31:0]];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  store_merge_rmw #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .err       (err)
  );

  store_merge_rmw_lane_merge #(.DATA_W(64)) u_lm64 (
    .rdata_i  (lm_rdata),
    .data_i   (lm_data),
    .size_i   (lm_size),
    .off_i    (lm_off),
    .merged_o (lm_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] mem_get(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  // Reference: what a store of this size/address/data does to memory.
  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                           output exp_t e);
    int off;
    off       = int'(a % 4);
    e.is_err  = (sz == 2'd3) || (sz == 2'd0 && off != 0) || (sz == 2'd1 && (off % 2) != 0);
    e.sub     = (sz != 2'd0);
    e.rd_seen = 1'b0;
    e.addr    = a - 32'(off);
    e.wdata   = '0;
    if (!e.is_err) begin
      e.wdata = mem_get(e.addr);
      if (sz == 2'd0) e.wdata = d;
      else if (sz == 2'd1) e.wdata[8*off +: 16] = d[15:0];
      else e.wdata[8*off +: 8] = d[7:0];
    end
  endtask

  // Present a request, wait for acceptance, record the expected response.
  task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int n;
    req_size  = sz;
    req_addr  = a;
    req_data  = d;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      chk("accept_timeout", 64'(n), 64'd0);
      req_valid = 1'b0;
      return;
    end
    ref_store(sz, a, d, e);
    e.t_acc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data  = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Memory model: data for a read is valid only in the cycle MEM_LAT after mem_rd.
  initial begin
    int due;
    logic [31:0] ra;
    due = -1;
    ra = '0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_rd && !reset) begin
        due = cyc + LAT;
        ra  = mem_addr;
      end
      if (cyc == due) mem_rdata = mem_get(ra);
      else mem_rdata = $urandom;
      if (mem_wr && !reset) mem[mem_addr] = mem_wdata;
    end
  end

  // Monitor: compare every strobe against the scoreboard head.
  initial begin
    exp_t e;
    int   exp_cyc;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        if (mem_rd || mem_wr) chk("rd_wr_exclusive", 64'(mem_rd & mem_wr), 64'd0);
        if (done || err) chk("done_err_exclusive", 64'(done & err), 64'd0);
        if (mem_rd) begin
          if (sb.size() == 0) chk("unexpected_rd", 64'(mem_rd), 64'd0);
          else begin
            chk("rd_cycle", 64'(cyc), 64'(sb[0].t_acc + 1));
            chk("rd_addr", 64'(mem_addr), 64'(sb[0].addr));
            chk("rd_allowed", 64'(sb[0].sub && !sb[0].is_err && !sb[0].rd_seen), 64'd1);
            sb[0].rd_seen = 1'b1;
          end
        end
        if (mem_wr || done || err) begin
          if (sb.size() == 0) chk("unexpected_out", {61'd0, mem_wr, done, err}, 64'd0);
          else begin
            e = sb.pop_front();
            exp_cyc = e.t_acc + (e.is_err ? 1 : (e.sub ? 2 + LAT : 1));
            chk("out_cycle", 64'(cyc), 64'(exp_cyc));
            chk("err", 64'(err), 64'(e.is_err));
            chk("done", 64'(done), 64'(!e.is_err));
            chk("mem_wr", 64'(mem_wr), 64'(!e.is_err));
            chk("read_issued", 64'(e.rd_seen), 64'(e.sub && !e.is_err));
            if (!e.is_err) begin
              chk("wr_addr", 64'(mem_addr), 64'(e.addr));
              chk("wr_data", 64'(mem_wdata), 64'(e.wdata));
            end
          end
        end else if (sb.size() > 0 && cyc > sb[0].t_acc + LAT + 6) begin
          chk("response_timeout", 64'(cyc), 64'(sb[0].t_acc));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_size  = '0;
    req_addr  = '0;
    req_data  = '0;
    lm_rdata  = '0;
    lm_data   = '0;
    lm_size   = '0;
    lm_off    = '0;
    @(posedge clk); #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases from the plan.
    mem[32'h200] = 32'h11223344;
    mem[32'h300] = 32'h11223344;
    issue(2'b00, 32'h100, 32'hDEADBEEF);
    issue(2'b10, 32'h203, 32'h000000AB);
    issue(2'b01, 32'h302, 32'h0000CAFE);
    issue(2'b01, 32'h401, 32'h12345678);
    issue(2'b00, 32'h402, 32'h12345678);
    issue(2'b11, 32'h500, 32'h12345678);
    drain();
    chk("plan_word_mem", 64'(mem[32'h100]), 64'h00000000DEADBEEF);
    chk("plan_byte_mem", 64'(mem[32'h200]), 64'h00000000AB223344);
    chk("plan_half_mem", 64'(mem[32'h300]), 64'h00000000CAFE3344);
    chk("plan_err_no_write", 64'(mem.exists(32'h400)), 64'd0);

    // 64-bit lane merge.
    lm_rdata = 64'd0; lm_data = 64'h7F; lm_size = SZ_BYTE; lm_off = 3'd5;
    #1 chk("lm64_byte_off5", lm_out, 64'h00007F0000000000);
    lm_rdata = '1; lm_data = 64'hBEEF; lm_size = SZ_HALF; lm_off = 3'd6;
    #1 chk("lm64_half_off6", lm_out, 64'hBEEFFFFFFFFFFFFF);
    @(posedge clk); #1;

    // Reset while waiting on the read.
    issue(2'b10, 32'h10, $urandom);
    @(posedge clk); #1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_mem_rd", 64'(mem_rd), 64'd0);
    chk("midrst_mem_wr", 64'(mem_wr), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    sb.delete();
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("postrst_req_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < LAT + 4; i++) begin
      @(posedge clk); #1;
    end

    // Random traffic, mixed back-to-back and gapped.
    for (int i = 0; i < 150; i++) begin
      issue(2'($urandom_range(0, 3)), 32'($urandom_range(0, 63)), $urandom);
      if ($urandom_range(0, 2) == 0) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
          @(posedge clk); #1;
        end
      end
    end
    drain();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
